pc_seq_ctrl: RTL and testbench
==============================

// Module: pc_seq_ctrl
// PURPOSE
//  Next-PC sequencer for the fetch stage of the 5-stage MIPS pipeline. Picks the NPC fed to the PC
//  register (exception entry, ERET, branch/jump redirect, PC+4) and drives its write enable.
//  Buffers a redirect that arrives while fetch is stalled, so no taken branch is lost.
//  Sits between the hazard unit / CP0 / decode redirect logic and the PC register.
// PARAMETERS
//  RESET_PC  32'h0000_3000  value of npc_o while reset is asserted
//  EXC_PC    32'h0000_4180  exception/interrupt handler entry
//  IM_LO     32'h0000_3000  lowest legal fetch address (align check only)
//  IM_HI     32'h0000_6ffc  highest legal fetch address (align check only)
// PORTS
//  clk             in   1   clock, rising edge
//  reset           in   1   asynchronous, active-low reset
//  stall_i         in   1   hazard unit stall of F/D
//  req_i           in   1   CP0 exception/interrupt request
//  eret_i          in   1   ERET in decode; return to epc_i
//  epc_i           in   32  CP0 EPC
//  redir_valid_i   in   1   branch taken / J / JAL / JR resolved in decode
//  redir_target_i  in   32  redirect target
//  pc_i            in   32  current PC from PC register
//  npc_o           out  32  next PC to PC register
//  pc_en_o         out  1   PC register write enable
//  flush_o         out  1   flush F/D register this cycle
//  pend_o          out  1   redirect buffered (state PEND)
//  adel_o          out  1   fetch address error (align check only)
// BEHAVIOUR
//  Reset (reset=0, async): state=SEQ, pend_target=0, npc_o=RESET_PC, pc_en_o=0, flush_o=0,
//   pend_o=0, adel_o=0. A reset asserted mid-PEND discards the buffered target.
//  States: SEQ (normal), PEND (target buffered), FLUSH (one cycle after req_i/eret_i).
//  pc_en_o = req_i | eret_i | ~stall_i (combinational). flush_o = req_i | eret_i.
//  npc_o priority, combinational, zero latency:
//   1 req_i -> EXC_PC;  2 eret_i -> epc_i;  3 state PEND -> pend_target;
//   4 redir_valid_i (not in FLUSH) -> redir_target_i;  5 else pc_i + 32'd4 (mod 2^32, wraps).
//  Transitions on posedge clk:
//   any state, req_i|eret_i -> FLUSH; pending target dropped.
//   SEQ: redir_valid_i & stall_i -> PEND, pend_target<=redir_target_i; else stay SEQ.
//   PEND: ~stall_i -> SEQ (buffered target written to PC this cycle);
//         stall_i & redir_valid_i -> stay PEND, pend_target<=redir_target_i (refresh).
//   FLUSH: ignores redir_valid_i (stale decode instruction); always -> SEQ after one cycle.
//  Simultaneous events: req_i beats eret_i beats pending target beats new redirect.
//  redir_valid_i with stall_i=0 in SEQ: redirect written directly; no PEND entry.
//  pend_o = (state==PEND), registered.
// CONFIGURATION
//  PC_ALIGN_CHECK_EN defined: adel_o = (pc_i[1:0]!=0) | (pc_i<IM_LO) | (pc_i>IM_HI), combinational.
//   A redirect target failing the same check is still taken; the error is flagged once it is the PC.
//  Not defined: adel_o tied to 0. IM_LO/IM_HI unused.
// STRUCTURE
//  Package pc_seq_pkg: state enum {SEQ, PEND, FLUSH} (2 bits), RESET_PC/EXC_PC defaults,
//   EXC_ADEL=5'd4 code for CP0 hookup.
//  Sub-module pc_redir_buf: pend_target register + load/clear control. Mux and FSM stay in top.
// TESTING
//  1 reset low, pc_i=X -> npc_o=32'h3000, pc_en_o=0. Release, pc_i=32'h3000 -> npc_o=32'h3004, pc_en_o=1.
//  2 redir_valid_i=1, target=32'h3100, stall_i=1 for 3 cycles -> pend_o=1, pc_en_o=0;
//    stall_i=0 -> npc_o=32'h3100, pc_en_o=1, pend_o=0 next cycle.
//  3 state PEND, stall_i=1, req_i=1 -> npc_o=32'h4180, pc_en_o=1, flush_o=1; next cycle state FLUSH,
//    buffered 32'h3100 never issued.
//  4 eret_i=1, epc_i=32'h3abc, redir_valid_i=1 -> npc_o=32'h3abc, then FLUSH ignores redir -> pc_i+4.
//  5 req_i & eret_i in same cycle -> npc_o=32'h4180. pc_i=32'hffff_fffc, idle -> npc_o=32'h0.
//  6 PC_ALIGN_CHECK_EN: pc_i=32'h3002 -> adel_o=1. pc_i=32'h7000 -> adel_o=1.
//    Without the macro -> adel_o=0 in both cases.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-stage next-PC sequencer.
// State encoding, default reset/exception vectors, legal fetch window,
// the CP0 code for fetch address errors, and the fetch address check.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        SEQ   = 2'd0,   // sequential fetch or direct redirect
        PEND  = 2'd1,   // redirect target held while fetch is stalled
        FLUSH = 2'd2    // one cycle after exception entry / ERET
    } pc_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;
    localparam logic [31:0] IM_LO_DEF    = 32'h0000_3000;
    localparam logic [31:0] IM_HI_DEF    = 32'h0000_6ffc;

    // ExcCode reported to CP0 for an instruction fetch address error.
    localparam logic [4:0]  EXC_ADEL     = 5'd4;

    // True when a fetch address is misaligned or outside instruction memory.
    function automatic logic fetch_addr_bad(input logic [31:0] pc,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
        return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
    endfunction

endpackage

// File: rtl/pc_redir_buf.sv
// Holding register for a redirect target that arrived while fetch was stalled.
// Ports: clk, rst_n (async active-low), load_i (capture target_i),
//        clr_i (drop held target, wins over load_i), target_i, target_o (held target).
module pc_redir_buf
    import pc_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        clr_i,
    input  logic [31:0] target_i,
    output logic [31:0] target_o
);

    logic [31:0] target_q;
    logic [31:0] target_d;

    always_comb begin
        target_d = target_q;
        if (clr_i) begin
            target_d = '0;
        end else if (load_i) begin
            target_d = target_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q <= '0;
        end else begin
            target_q <= target_d;
        end
    end

    assign target_o = target_q;

endmodule

// File: rtl/pc_seq_ctrl.sv
// Next-PC sequencer: selects exception entry, ERET return, buffered or live
// redirect, or PC+4, and drives the PC write enable and F/D flush.
// Ports: clk, reset (async active-low); stall_i, req_i, eret_i, epc_i,
//        redir_valid_i, redir_target_i, pc_i in; npc_o, pc_en_o, flush_o, pend_o, adel_o out.
// Optional macro PC_ALIGN_CHECK_EN enables the fetch address check on adel_o.
module pc_seq_ctrl
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] EXC_PC   = EXC_PC_DEF,
    parameter logic [31:0] IM_LO    = IM_LO_DEF,
    parameter logic [31:0] IM_HI    = IM_HI_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        req_i,
    input  logic        eret_i,
    input  logic [31:0] epc_i,
    input  logic        redir_valid_i,
    input  logic [31:0] redir_target_i,
    input  logic [31:0] pc_i,
    output logic [31:0] npc_o,
    output logic        pc_en_o,
    output logic        flush_o,
    output logic        pend_o,
    output logic        adel_o
);

    pc_state_e   state_q;
    pc_state_e   state_d;
    logic        buf_load;
    logic        buf_clr;
    logic [31:0] pend_target;
    logic        trap;

    assign trap = req_i | eret_i;

    pc_redir_buf u_redir_buf (
        .clk      (clk),
        .rst_n    (reset),
        .load_i   (buf_load),
        .clr_i    (buf_clr),
        .target_i (redir_target_i),
        .target_o (pend_target)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SEQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        buf_load = 1'b0;
        buf_clr  = 1'b0;
        if (trap) begin
            // Exception entry / ERET kills any buffered redirect.
            state_d = FLUSH;
            buf_clr = 1'b1;
        end else begin
            case (state_q)
                SEQ: begin
                    // An unstalled redirect goes straight to the PC; only a stalled one is held.
                    if (redir_valid_i && stall_i) begin
                        state_d  = PEND;
                        buf_load = 1'b1;
                    end
                end
                PEND: begin
                    if (!stall_i) begin
                        state_d = SEQ;
                        buf_clr = 1'b1;
                    end else if (redir_valid_i) begin
                        // A younger resolved redirect replaces the held one.
                        buf_load = 1'b1;
                    end
                end
                FLUSH: begin
                    // Decode still holds the squashed instruction; its redirect is stale.
                    state_d = SEQ;
                end
                default: begin
                    state_d = SEQ;
                end
            endcase
        end
    end

    always_comb begin
        npc_o = pc_i + 32'd4;
        if (!reset) begin
            npc_o = RESET_PC;
        end else if (req_i) begin
            npc_o = EXC_PC;
        end else if (eret_i) begin
            npc_o = epc_i;
        end else if (state_q == PEND) begin
            npc_o = pend_target;
        end else if (redir_valid_i && (state_q != FLUSH)) begin
            npc_o = redir_target_i;
        end
    end

    assign pc_en_o = reset & (trap | ~stall_i);
    assign flush_o = reset & trap;
    assign pend_o  = (state_q == PEND);

`ifdef PC_ALIGN_CHECK_EN
    // Checks the PC already fetched, so a bad redirect target is flagged one step later.
    assign adel_o = reset & fetch_addr_bad(pc_i, IM_LO, IM_HI);
`else
    logic unused_im_window;
    assign unused_im_window = ^{IM_LO, IM_HI};
    assign adel_o = 1'b0;
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
module tb_pc_seq_ctrl;

`ifdef PC_ALIGN_CHECK_EN
    localparam bit ADEL_ON = 1'b1;
`else
    localparam bit ADEL_ON = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        req_i;
    logic        eret_i;
    logic [31:0] epc_i;
    logic        redir_valid_i;
    logic [31:0] redir_target_i;
    logic [31:0] pc_i;
    logic [31:0] npc_o;
    logic        pc_en_o;
    logic        flush_o;
    logic        pend_o;
    logic        adel_o;

    int n_cmp = 0;
    int n_bad = 0;

    pc_seq_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .stall_i        (stall_i),
        .req_i          (req_i),
        .eret_i         (eret_i),
        .epc_i          (epc_i),
        .redir_valid_i  (redir_valid_i),
        .redir_target_i (redir_target_i),
        .pc_i           (pc_i),
        .npc_o          (npc_o),
        .pc_en_o        (pc_en_o),
        .flush_o        (flush_o),
        .pend_o         (pend_o),
        .adel_o         (adel_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          st, rq, er, rd;
        logic [31:0] tgt, epc, pc;
        logic [31:0] e_npc;
        bit          e_en, e_fl, e_pd, e_ad;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit st, input bit rq, input bit er, input bit rd,
                       input logic [31:0] tgt, input logic [31:0] epc, input logic [31:0] pc,
                       input logic [31:0] e_npc, input bit e_en, input bit e_fl,
                       input bit e_pd, input bit e_ad);
        vec_t v;
        v.st = st; v.rq = rq; v.er = er; v.rd = rd;
        v.tgt = tgt; v.epc = epc; v.pc = pc;
        v.e_npc = e_npc; v.e_en = e_en; v.e_fl = e_fl; v.e_pd = e_pd; v.e_ad = e_ad;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic bit bad_addr(input logic [31:0] pc);
        return ADEL_ON && ((pc % 4) != 0 || pc < 32'h3000 || pc > 32'h6ffc);
    endfunction

    task automatic drive(input bit st, input bit rq, input bit er, input bit rd,
                         input logic [31:0] tgt, input logic [31:0] epc, input logic [31:0] pc);
        stall_i = st; req_i = rq; eret_i = er; redir_valid_i = rd;
        redir_target_i = tgt; epc_i = epc; pc_i = pc;
    endtask

    // Reference model state: whether a redirect is being held, its target,
    // and whether the previous cycle took an exception or ERET.
    bit          m_hold;
    logic [31:0] m_tgt;
    bit          m_after_trap;

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 32'h0, 'x);
        #3;
        chk("reset npc",   npc_o,   32'h3000);
        chk("reset pc_en", pc_en_o, 32'h0);
        chk("reset flush", flush_o, 32'h0);
        chk("reset pend",  pend_o,  32'h0);
        chk("reset adel",  adel_o,  32'h0);
        @(posedge clk);
        #2 reset = 1'b1;

        //   st rq er rd  tgt           epc           pc            npc           en fl pd ad
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h3000,     32'h3004,     1, 0, 0, 0);
        add(1, 0, 0, 1, 32'h3100,     32'h0,        32'h3004,     32'h3100,     0, 0, 0, 0);
        add(1, 0, 0, 0, 32'h0,        32'h0,        32'h3004,     32'h3100,     0, 0, 1, 0);
        add(1, 0, 0, 0, 32'h0,        32'h0,        32'h3004,     32'h3100,     0, 0, 1, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h3004,     32'h3100,     1, 0, 1, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h3100,     32'h3104,     1, 0, 0, 0);
        add(1, 0, 0, 1, 32'h3100,     32'h0,        32'h3104,     32'h3100,     0, 0, 0, 0);
        add(1, 1, 0, 0, 32'h0,        32'h0,        32'h3104,     32'h4180,     1, 1, 1, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h4180,     32'h4184,     1, 0, 0, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h4184,     32'h4188,     1, 0, 0, 0);
        add(0, 0, 1, 1, 32'h3200,     32'h3abc,     32'h4188,     32'h3abc,     1, 1, 0, 0);
        add(0, 0, 0, 1, 32'h3200,     32'h0,        32'h3abc,     32'h3ac0,     1, 0, 0, 0);
        add(0, 0, 0, 1, 32'h3200,     32'h0,        32'h3ac0,     32'h3200,     1, 0, 0, 0);
        add(0, 1, 1, 0, 32'h0,        32'h3abc,     32'h3200,     32'h4180,     1, 1, 0, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'hffff_fffc, 32'h0,       1, 0, 0, ADEL_ON);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'hffff_fffc, 32'h0,       1, 0, 0, ADEL_ON);
        add(1, 0, 0, 1, 32'h3300,     32'h0,        32'h3000,     32'h3300,     0, 0, 0, 0);
        add(1, 0, 0, 1, 32'h3400,     32'h0,        32'h3000,     32'h3300,     0, 0, 1, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h3000,     32'h3400,     1, 0, 1, 0);
        add(1, 0, 0, 1, 32'h3500,     32'h0,        32'h3400,     32'h3500,     0, 0, 0, 0);
        add(1, 0, 1, 0, 32'h0,        32'h3abc,     32'h3400,     32'h3abc,     1, 1, 1, 0);
        add(1, 0, 0, 0, 32'h0,        32'h0,        32'h3abc,     32'h3ac0,     0, 0, 0, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h3ac0,     32'h3ac4,     1, 0, 0, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h3002,     32'h3006,     1, 0, 0, ADEL_ON);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h7000,     32'h7004,     1, 0, 0, ADEL_ON);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h6ffc,     32'h7000,     1, 0, 0, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h2ffc,     32'h3000,     1, 0, 0, ADEL_ON);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].st, vecs[i].rq, vecs[i].er, vecs[i].rd,
                  vecs[i].tgt, vecs[i].epc, vecs[i].pc);
            #3;
            chk($sformatf("row%0d npc",   i), npc_o,   vecs[i].e_npc);
            chk($sformatf("row%0d pc_en", i), pc_en_o, {31'b0, vecs[i].e_en});
            chk($sformatf("row%0d flush", i), flush_o, {31'b0, vecs[i].e_fl});
            chk($sformatf("row%0d pend",  i), pend_o,  {31'b0, vecs[i].e_pd});
            chk($sformatf("row%0d adel",  i), adel_o,  {31'b0, vecs[i].e_ad});
        end

        // Reset while a redirect is held must discard it.
        @(posedge clk);
        #1 drive(1, 0, 0, 1, 32'h3600, 32'h0, 32'h3000);
        #3 chk("prst capture npc", npc_o, 32'h3600);
        @(posedge clk);
        #1 redir_valid_i = 1'b0;
        #1 chk("prst held pend", pend_o, 32'h1);
        #1 reset = 1'b0;
        #1;
        chk("prst async pend",  pend_o,  32'h0);
        chk("prst async npc",   npc_o,   32'h3000);
        chk("prst async pc_en", pc_en_o, 32'h0);
        @(posedge clk);
        #2 reset = 1'b1;
        drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h3000);
        #1;
        chk("prst after npc",  npc_o,   32'h3004);
        chk("prst after pend", pend_o,  32'h0);
        chk("prst after en",   pc_en_o, 32'h1);

        // Randomized run against the behavioural model.
        m_hold = 0;
        m_tgt = 32'h0;
        m_after_trap = 0;
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] e_npc, pc_r, tgt_r, epc_r;
            bit st, rq, er, rd;
            @(posedge clk);
            #1;
            st = ($urandom_range(0, 99) < 40);
            rq = ($urandom_range(0, 99) < 5);
            er = ($urandom_range(0, 99) < 6);
            rd = ($urandom_range(0, 99) < 35);
            pc_r  = $urandom_range(0, 1) ? (32'h3000 + 32'($urandom_range(0, 32'hfff)) * 4) : $urandom;
            tgt_r = $urandom_range(0, 1) ? (32'h3000 + 32'($urandom_range(0, 32'hfff)) * 4) : $urandom;
            epc_r = $urandom;
            drive(st, rq, er, rd, tgt_r, epc_r, pc_r);
            #3;
            if (rq)                       e_npc = 32'h4180;
            else if (er)                  e_npc = epc_r;
            else if (m_hold)              e_npc = m_tgt;
            else if (rd && !m_after_trap) e_npc = tgt_r;
            else                          e_npc = pc_r + 32'd4;
            chk($sformatf("rnd%0d npc", n),   npc_o,   e_npc);
            chk($sformatf("rnd%0d pc_en", n), pc_en_o, {31'b0, (rq || er || !st)});
            chk($sformatf("rnd%0d flush", n), flush_o, {31'b0, (rq || er)});
            chk($sformatf("rnd%0d pend", n),  pend_o,  {31'b0, m_hold});
            chk($sformatf("rnd%0d adel", n),  adel_o,  {31'b0, bad_addr(pc_r)});
            // Advance model to what the coming clock edge commits.
            if (rq || er) begin
                m_hold = 0;
                m_after_trap = 1;
            end else if (m_after_trap) begin
                m_after_trap = 0;
            end else if (m_hold) begin
                if (!st)     m_hold = 0;
                else if (rd) m_tgt = tgt_r;
            end else if (rd && st) begin
                m_hold = 1;
                m_tgt = tgt_r;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
